// File: rtl/rb_stream_reader.sv
// rb_stream_reader: reads a byte range out of the row-buffer BRAM and emits
// it as a valid/ready byte stream, walking consecutive rows as needed.
module rb_stream_reader #(
    parameter int ROW_BYTES = 258,
    parameter int ADDR_W    = 16,
    parameter int LEN_W     = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_BRAM_addr,
    input  logic [LEN_W-1:0]       cmd_offset,
    input  logic [LEN_W-1:0]       cmd_length,
    output logic [ADDR_W-1:0]      BRAM_read_addr,
    input  logic [ROW_BYTES*8-1:0] BRAM_read_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   out_last,
    output logic                   done,
    output logic                   err
);

    localparam int ROW_W = ROW_BYTES * 8;
    localparam int IDX_W = 9;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_BYTES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, CAPT, STREAM} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   row_addr_q, row_addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [ROW_W-1:0]    row_reg_q, row_reg_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ROW_W-1:0]    row_shift;

    // State and datapath registers; reset abandons any stream in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_addr_q  <= '0;
            rd_addr_q   <= '0;
            byte_idx_q  <= '0;
            remaining_q <= '0;
            row_reg_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_addr_q  <= row_addr_d;
            rd_addr_q   <= rd_addr_d;
            byte_idx_q  <= byte_idx_d;
            remaining_q <= remaining_d;
            row_reg_q   <= row_reg_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state: accept command, one wait cycle for the BRAM, capture, stream.
    always_comb begin
        state_d     = state_q;
        row_addr_d  = row_addr_q;
        rd_addr_d   = rd_addr_q;
        byte_idx_d  = byte_idx_q;
        remaining_d = remaining_q;
        row_reg_d   = row_reg_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_offset >= LEN_W'(ROW_BYTES)) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (cmd_length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rd_addr_d   = cmd_BRAM_addr;
                        row_addr_d  = cmd_BRAM_addr;
                        byte_idx_d  = IDX_W'(cmd_offset);
                        remaining_d = cmd_length;
                        state_d     = WAIT;
                    end
                end
            end
            WAIT: begin
                state_d = CAPT;
            end
            CAPT: begin
                row_reg_d   = BRAM_read_data;
                out_valid_d = 1'b1;
                out_last_d  = (remaining_q == LEN_W'(1));
                state_d     = STREAM;
            end
            STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (remaining_q == LEN_W'(1)) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end else if (byte_idx_q == LAST_IDX) begin
                        // End of row: fetch the next row, wrapping the address.
                        byte_idx_d  = '0;
                        remaining_d = remaining_q - LEN_W'(1);
                        row_addr_d  = row_addr_q + ADDR_W'(1);
                        rd_addr_d   = row_addr_q + ADDR_W'(1);
                        out_valid_d = 1'b0;
                        state_d     = WAIT;
                    end else begin
                        byte_idx_d  = byte_idx_q + IDX_W'(1);
                        remaining_d = remaining_q - LEN_W'(1);
                        out_last_d  = (remaining_q == LEN_W'(2));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte select: byte 0 sits in the most significant bits of the row.
    always_comb begin
        row_shift = row_reg_q << {byte_idx_q, 3'b000};
        out_data  = row_shift[ROW_W-1 -: 8];
    end

    assign cmd_ready      = (state_q == IDLE);
    assign BRAM_read_addr = rd_addr_q;
    assign out_valid      = out_valid_q;
    assign out_last       = out_last_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule
